final_perm: RTL and testbench

FINAL_PERM -- requirements
Module: final_perm

---
 rtl/final_perm_if.sv | 16 +
 rtl/final_perm.sv | 156 +++++++++++++++
 tb/tb_final_perm.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/final_perm_if.sv
// -----------------------------------------------------------------------------
// final_perm_if
//   Valid/ready stream that carries one 64-bit permuted DES word
//   (bit 1 = MSB).
//   master : drives data/valid and samples ready
//   slave  : samples data/valid and drives ready
//   A word moves on every rising edge where valid & ready are both high.
// -----------------------------------------------------------------------------
interface final_perm_if;
    logic [1:64] data;
    logic        valid;
    logic        ready;

    modport master (output data, output valid, input  ready);
    modport slave  (input  data, input  valid, output ready);
endinterface

// File: rtl/final_perm.sv
// -----------------------------------------------------------------------------
// final_perm
//   DES output stage. It forms the 64-bit preoutput from the round-16 halves,
//   applies the final permutation IP^-1, and queues the result in a 2-deep
//   valid/ready FIFO.
//
//   Ports
//     clk_i     : clock; all state changes on the rising edge
//     rst_n_i   : synchronous active-low reset (clears count, pointers, entries)
//     l16_i     : [1:32] left half after round 16
//     r16_i     : [1:32] right half after round 16
//     valid_i   : l16_i/r16_i carry a word this cycle
//     ready_o   : a word can be accepted this cycle (FIFO not full)
//     flush_i   : synchronous discard of every buffered word
//     fp_box_o  : [1:64] head-of-FIFO result (ciphertext or plaintext)
//     valid_o   : fp_box_o holds a word
//     ready_i   : downstream takes fp_box_o this cycle
//
//   Parameter
//     SWAP_EN   : 1 -> preoutput = R16||L16 (the normal DES final swap)
//                 0 -> preoutput = L16||R16 (the swap happened upstream)
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// fp_fifo
//   Two-entry FIFO between the permutation network and the block outputs.
//   Ports
//     clk_i, rst_n_i : clock and synchronous active-low reset
//     flush_i        : drop every stored word; a push or pop on the same
//                      edge is discarded as well
//     s_in           : slave side; the permuted word arrives here
//     m_out          : master side; the head entry leaves here
// -----------------------------------------------------------------------------
module fp_fifo (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          flush_i,
    final_perm_if.slave   s_in,
    final_perm_if.master  m_out
);

    logic [1:64] r_mem [0:1];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;

    logic        w_push;
    logic        w_pop;

    // ready depends only on stored state, so no path runs from ready_i
    // to ready_o.
    assign s_in.ready  = (r_count != 2'd2);
    assign m_out.valid = (r_count != 2'd0);
    assign m_out.data  = r_mem[r_rd_ptr];

    assign w_push = s_in.valid  & s_in.ready;
    assign w_pop  = m_out.valid & m_out.ready;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            // Entries are cleared as well, so the output reads 0 until the
            // first push.
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (flush_i) begin
            // Entries are left as they are. They are unreachable once the
            // count is 0.
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= s_in.data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            // A push and a pop on the same edge leave the count unchanged.
            // With count=1 the new word becomes the head on the next cycle,
            // so no bubble appears.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

module final_perm #(
    parameter bit SWAP_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [1:32] l16_i,
    input  logic [1:32] r16_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        flush_i,
    output logic [1:64] fp_box_o,
    output logic        valid_o,
    input  logic        ready_i
);

    // IP^-1: output bit k takes preoutput bit FP_TBL[k]. Bit 1 is the MSB.
    localparam logic [6:0] FP_TBL [1:64] = '{
        7'd40, 7'd8, 7'd48, 7'd16, 7'd56, 7'd24, 7'd64, 7'd32,
        7'd39, 7'd7, 7'd47, 7'd15, 7'd55, 7'd23, 7'd63, 7'd31,
        7'd38, 7'd6, 7'd46, 7'd14, 7'd54, 7'd22, 7'd62, 7'd30,
        7'd37, 7'd5, 7'd45, 7'd13, 7'd53, 7'd21, 7'd61, 7'd29,
        7'd36, 7'd4, 7'd44, 7'd12, 7'd52, 7'd20, 7'd60, 7'd28,
        7'd35, 7'd3, 7'd43, 7'd11, 7'd51, 7'd19, 7'd59, 7'd27,
        7'd34, 7'd2, 7'd42, 7'd10, 7'd50, 7'd18, 7'd58, 7'd26,
        7'd33, 7'd1, 7'd41, 7'd9,  7'd49, 7'd17, 7'd57, 7'd25
    };

    logic [1:64] w_pre;
    logic [1:64] w_perm;

    // The swap is fixed at elaboration, so it costs only wiring.
    assign w_pre = SWAP_EN ? {r16_i, l16_i} : {l16_i, r16_i};

    // The permutation is pure wiring. It runs before the buffer, so the
    // FIFO stores only finished words.
    genvar k;
    generate
        for (k = 1; k <= 64; k++) begin : g_fp
            assign w_perm[k] = w_pre[FP_TBL[k]];
        end
    endgenerate

    final_perm_if u_in  ();
    final_perm_if u_out ();

    assign u_in.data   = w_perm;
    assign u_in.valid  = valid_i;
    assign ready_o     = u_in.ready;

    assign fp_box_o    = u_out.data;
    assign valid_o     = u_out.valid;
    assign u_out.ready = ready_i;

    fp_fifo u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush_i (flush_i),
        .s_in    (u_in),
        .m_out   (u_out)
    );

endmodule

// File: tb/tb_final_perm.sv
// -----------------------------------------------------------------------------
// tb_final_perm
//   Bench for final_perm.
//   - DUT u_dut1 uses SWAP_EN=1.
//   - DUT u_dut2 uses SWAP_EN=0 and receives the two halves exchanged, so it
//     must produce the same output stream as u_dut1.
//   - The reference model computes IP^-1 arithmetically and tracks the FIFO
//     as a queue of expected words.
// -----------------------------------------------------------------------------
module tb_final_perm;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] l16, r16;
    logic        valid_i, flush_i;
    logic        ready_o, ready_o2, valid_o2;
    logic [1:64] fp_box_o2;

    final_perm_if mon ();   // DUT1 output side: data/valid from DUT, ready from bench

    int n_chk = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    final_perm #(.SWAP_EN(1'b1)) u_dut1 (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .l16_i(l16), .r16_i(r16),
        .valid_i(valid_i), .ready_o(ready_o), .flush_i(flush_i),
        .fp_box_o(mon.data), .valid_o(mon.valid), .ready_i(mon.ready)
    );

    final_perm #(.SWAP_EN(1'b0)) u_dut2 (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .l16_i(r16), .r16_i(l16),
        .valid_i(valid_i), .ready_o(ready_o2), .flush_i(flush_i),
        .fp_box_o(fp_box_o2), .valid_o(valid_o2), .ready_i(mon.ready)
    );

    // IP^-1 in closed form. Output bit k (1-based, MSB first) sits at row
    // (k-1)/8 and column (k-1)%8 of the table.
    //   even columns take source bit 40+8*(col/2)-row
    //   odd columns take source bit 8+8*(col/2)-row
    function automatic logic [63:0] model_fp(logic [31:0] l, logic [31:0] r, bit swap);
        logic [63:0] p, o;
        int row, col, src;
        p = swap ? {r, l} : {l, r};
        o = '0;
        for (int kk = 1; kk <= 64; kk++) begin
            row = (kk - 1) / 8;
            col = (kk - 1) % 8;
            src = ((col % 2) == 0) ? (40 + 8 * (col / 2) - row) : (8 + 8 * (col / 2) - row);
            o[64 - kk] = p[64 - src];
        end
        return o;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference FIFO contents, head at index 0.
    logic [63:0] q[$];
    bit live = 1'b0;      // set once a reset has been applied
    bit zero_out = 1'b0;  // output must read 0: after reset, before the first push

    // Compare on the falling edge. Then advance the model using the inputs
    // that the next rising edge will sample.
    always @(negedge clk_i) begin
        if (live) begin
            chk("valid_o", mon.valid, (q.size() > 0));
            chk("ready_o", ready_o,   (q.size() < 2));
            chk("valid_o_swap0", valid_o2, (q.size() > 0));
            chk("ready_o_swap0", ready_o2, (q.size() < 2));
            if (q.size() > 0) begin
                chk("fp_box_o", mon.data, q[0]);
                chk("fp_box_o_swap0", fp_box_o2, q[0]);
            end else if (zero_out) begin
                chk("fp_box_o_rst0", mon.data, 64'h0);
            end
        end
        if (!rst_n_i) begin
            q.delete();
            live     = 1'b1;
            zero_out = 1'b1;
        end else if (flush_i) begin
            q.delete();
        end else begin
            bit pu, po;
            pu = valid_i && (q.size() < 2);
            po = mon.ready && (q.size() > 0);
            if (po) void'(q.pop_front());
            if (pu) begin
                q.push_back(model_fp(l16, r16, 1'b1));
                zero_out = 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    localparam logic [31:0] KAT_L = 32'h43423234;
    localparam logic [31:0] KAT_R = 32'h0A4CD995;
    localparam logic [63:0] KAT_O = 64'h85E813540F0AB405;

    logic [63:0] w0, w1;

    initial begin
        rst_n_i = 1'b0; valid_i = 1'b0; flush_i = 1'b0; mon.ready = 1'b0;
        l16 = '0; r16 = '0;
        cyc(); cyc();
        chk("rst_valid", mon.valid, 1'b0);
        chk("rst_ready", ready_o, 1'b1);
        chk("rst_fp", mon.data, 64'h0);
        rst_n_i = 1'b1;

        // Known-answer vector, latency 1
        l16 = KAT_L; r16 = KAT_R; valid_i = 1'b1; mon.ready = 1'b1;
        cyc(); valid_i = 1'b0;
        chk("kat_valid", mon.valid, 1'b1);
        chk("kat_fp", mon.data, KAT_O);
        chk("kat_fp_swap0", fp_box_o2, KAT_O);
        cyc();

        // Single bit and all ones
        l16 = '0; r16 = 32'h80000000; valid_i = 1'b1;
        cyc(); valid_i = 1'b0;
        chk("bit1_fp", mon.data, 64'h0000000000000040);
        cyc();
        l16 = '1; r16 = '1; valid_i = 1'b1;
        cyc(); valid_i = 1'b0;
        chk("ones_fp", mon.data, 64'hFFFFFFFFFFFFFFFF);
        cyc();

        // Backpressure: 3 back-to-back words, only 2 fit
        mon.ready = 1'b0;
        w0 = model_fp(32'h00001000, ~32'h00001000, 1'b1);
        w1 = model_fp(32'h00001001, ~32'h00001001, 1'b1);
        for (int i = 0; i < 3; i++) begin
            l16 = 32'h00001000 + i; r16 = ~l16; valid_i = 1'b1;
            cyc();
            chk("bp_head_stable", mon.data, w0);
            if (i >= 1) chk("bp_full_ready", ready_o, 1'b0);
        end
        valid_i = 1'b0; mon.ready = 1'b1;
        cyc();
        chk("bp_second", mon.data, w1);
        chk("bp_ready_after_pop", ready_o, 1'b1);
        cyc();
        chk("bp_drained", mon.valid, 1'b0);

        // Steady streaming at count=1: push and pop every cycle, no bubble
        mon.ready = 1'b0; l16 = 32'h00002000; r16 = 32'h5A5A5A5A; valid_i = 1'b1;
        cyc(); mon.ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            l16 = 32'h00002000 + i; r16 = $urandom;
            cyc();
            chk("stream_valid", mon.valid, 1'b1);
            chk("stream_ready", ready_o, 1'b1);
        end
        valid_i = 1'b0;
        cyc(); cyc();

        // Flush while full, with a push in the same cycle
        mon.ready = 1'b0; valid_i = 1'b1; l16 = 32'hAAAA0001; r16 = 32'h1;
        cyc(); l16 = 32'hAAAA0002;
        cyc();
        chk("flush_full_ready", ready_o, 1'b0);
        flush_i = 1'b1; l16 = 32'hBBBB0003;
        cyc(); flush_i = 1'b0; valid_i = 1'b0;
        chk("flush_valid", mon.valid, 1'b0);
        chk("flush_ready", ready_o, 1'b1);
        mon.ready = 1'b1;
        repeat (3) cyc();
        chk("flush_no_ghost", mon.valid, 1'b0);

        // Flush beats a simultaneous push and pop at count=1
        mon.ready = 1'b0; valid_i = 1'b1; l16 = 32'hCCCC0001;
        cyc(); mon.ready = 1'b1; flush_i = 1'b1; l16 = 32'hCCCC0002;
        cyc(); flush_i = 1'b0; valid_i = 1'b0;
        chk("flush_pp_valid", mon.valid, 1'b0);

        // Reset while full, then the known-answer vector again
        mon.ready = 1'b0; valid_i = 1'b1; l16 = 32'hDDDD0001;
        cyc(); l16 = 32'hDDDD0002;
        cyc(); valid_i = 1'b0; rst_n_i = 1'b0;
        cyc(); rst_n_i = 1'b1;
        chk("rst2_valid", mon.valid, 1'b0);
        chk("rst2_ready", ready_o, 1'b1);
        chk("rst2_fp", mon.data, 64'h0);
        l16 = KAT_L; r16 = KAT_R; valid_i = 1'b1;
        cyc(); valid_i = 1'b0; mon.ready = 1'b1;
        chk("rst2_kat", mon.data, KAT_O);
        cyc();

        // Mixed traffic, checked cycle by cycle against the model
        for (int i = 0; i < 300; i++) begin
            valid_i   = $urandom_range(0, 1);
            mon.ready = ($urandom_range(0, 3) != 0);
            flush_i   = ($urandom_range(0, 15) == 0);
            l16 = $urandom; r16 = $urandom;
            cyc();
        end
        valid_i = 1'b0; flush_i = 1'b0; mon.ready = 1'b1;
        repeat (3) cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
